// File: rtl/minf_share_arbiter_pkg.sv
// Shared types and helpers for the shared float-minimum arbiter.
// Latency: n/a (package only).
// Backpressure: n/a. Provides tag/credit width helpers and the round-robin select.
package minf_share_arbiter_pkg;

  // Upper bound on requesters handled by the round-robin select.
  localparam int unsigned RR_MAX   = 32;
  localparam int unsigned RR_IDX_W = 5;

  typedef struct packed {
    logic                vld;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width able to hold 0..depth inclusive.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Mask-and-priority round robin: lowest requester at or above ptr wins;
  // if none, the lowest requester overall wins (wrap-around).
  function automatic rr_pick_t rr_select(input logic [RR_MAX-1:0] req,
                                         input logic [RR_IDX_W-1:0] ptr);
    logic [RR_MAX-1:0] hi;
    rr_pick_t          pick;
    hi   = req & ({RR_MAX{1'b1}} << ptr);
    pick = '0;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick.vld = 1'b1;
        pick.idx = RR_IDX_W'(i);
      end
    end
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      if (hi[i]) pick.idx = RR_IDX_W'(i);
    end
    return pick;
  endfunction

endpackage

// File: rtl/minf_share_result_fifo.sv
// First-word-fall-through result FIFO, one per requester.
// Latency: a push is visible on pop_data_o/!empty_o the following cycle.
// Backpressure: push while full is only legal together with a pop (upstream credits guarantee it).
// Ports: clk/rst (sync, active-high), push_i/push_dat_i, pop_i, pop_dat_o, full_o, empty_o.
module minf_share_result_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_dat_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_dat_o,
  output logic                  full_o,
  output logic                  empty_o
);
  import minf_share_arbiter_pkg::*;

  localparam int PTR_W = min1_clog2(FIFO_DEPTH);
  localparam int CNT_W = credit_width(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign do_pop    = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push   = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && full_o && !pop_i));

endmodule

// File: rtl/minf_share_arbiter.sv
// Round-robin share of one fixed-latency float-min unit among NUM_REQ requesters.
// Latency: LATENCY+1 cycles from operand handshake to outs_valid (minimum).
// Backpressure: per-requester credits (FIFO_DEPTH) gate issue so the unit never stalls.
// Ports: clk/rst; ins_lhs/ins_rhs/ins_valid/ins_ready operand channels;
// outs/outs_valid/outs_ready result channels; unit_lhs/unit_rhs/unit_valid/unit_result to the unit.
module minf_share_arbiter
  import minf_share_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ins_lhs,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ins_rhs,
  input  logic [NUM_REQ-1:0]            ins_valid,
  output logic [NUM_REQ-1:0]            ins_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] outs,
  output logic [NUM_REQ-1:0]            outs_valid,
  input  logic [NUM_REQ-1:0]            outs_ready,
  output logic [DATA_WIDTH-1:0]         unit_lhs,
  output logic [DATA_WIDTH-1:0]         unit_rhs,
  output logic                          unit_valid,
  input  logic [DATA_WIDTH-1:0]         unit_result
);

  localparam int TAG_W  = min1_clog2(NUM_REQ);
  localparam int CRED_W = credit_width(FIFO_DEPTH);

  logic [TAG_W-1:0]  ptr_q, ptr_d;
  logic [NUM_REQ-1:0] elig, res_push, res_pop, fifo_full, fifo_empty;
  rr_pick_t          pick;
  logic              grant_vld;
  logic [TAG_W-1:0]  grant_idx, sel_idx;
  logic [CRED_W-1:0] credit_q [NUM_REQ];
  logic [CRED_W-1:0] credit_d [NUM_REQ];
  logic [LATENCY-1:0] tv_q;
  logic [TAG_W-1:0]  tag_q [LATENCY];

  // ---------------- arbitration ----------------
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) elig[i] = ins_valid[i] && (credit_q[i] != '0);
  end

  assign pick      = rr_select(RR_MAX'(elig), RR_IDX_W'(ptr_q));
  // Nothing is granted while reset is held, so no operand is consumed then.
  assign grant_vld = pick.vld && !rst;
  assign grant_idx = TAG_W'(pick.idx);
  assign sel_idx   = grant_vld ? grant_idx : ptr_q;

  assign unit_valid = grant_vld;
  assign unit_lhs   = ins_lhs[sel_idx*DATA_WIDTH +: DATA_WIDTH];
  assign unit_rhs   = ins_rhs[sel_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    ins_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) ins_ready[i] = grant_vld && (grant_idx == TAG_W'(i));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // ---------------- tag pipeline ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      tv_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      tv_q[0] <= grant_vld;
      for (int k = 1; k < LATENCY; k++) tv_q[k] <= tv_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_q[0] <= grant_idx;
    for (int k = 1; k < LATENCY; k++) tag_q[k] <= tag_q[k-1];
  end

  // ---------------- credits ----------------
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      res_push[i] = tv_q[LATENCY-1] && (tag_q[LATENCY-1] == TAG_W'(i));
      res_pop[i]  = outs_valid[i] && outs_ready[i];
      credit_d[i] = credit_q[i];
      if (ins_ready[i] && !res_pop[i])      credit_d[i] = credit_q[i] - 1'b1;
      else if (!ins_ready[i] && res_pop[i]) credit_d[i] = credit_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) credit_q[i] <= CRED_W'(FIFO_DEPTH);
      else     credit_q[i] <= credit_d[i];
    end
  end

  // ---------------- result FIFOs ----------------
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    minf_share_result_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (res_push[i]),
      .push_dat_i(unit_result),
      .pop_i     (res_pop[i]),
      .pop_dat_o (outs[i*DATA_WIDTH +: DATA_WIDTH]),
      .full_o    (fifo_full[i]),
      .empty_o   (fifo_empty[i])
    );
    assign outs_valid[i] = !fifo_empty[i];

    a_credit_max: assert property (@(posedge clk) disable iff (rst)
      credit_q[i] <= CRED_W'(FIFO_DEPTH));
    a_credit_nonneg: assert property (@(posedge clk) disable iff (rst)
      !(ins_ready[i] && credit_q[i] == '0));
    a_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
      !(res_push[i] && fifo_full[i] && !res_pop[i]));
  end

endmodule

// File: tb/tb_minf_share_arbiter.sv
`timescale 1ns/1ps
module tb_minf_share_arbiter;
  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int DEP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Operands stay positive and finite, so an unsigned compare orders them like floats.
  function automatic logic [31:0] fmin(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [31:0] rnd_op(input int i);
    return {1'b0, 8'($urandom_range(1, 254)), 21'($urandom), 2'(i)};
  endfunction

  // ---------------- instance A: LATENCY=1 ----------------
  logic              a_rst;
  logic [NR*DW-1:0]  a_lhs, a_rhs, a_outs;
  logic [NR-1:0]     a_valid, a_ready, a_ovalid, a_oready;
  logic [DW-1:0]     a_ulhs, a_urhs, a_ures;
  logic              a_uvalid;

  minf_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .LATENCY(1), .FIFO_DEPTH(DEP)) dut_a (
    .clk(clk), .rst(a_rst), .ins_lhs(a_lhs), .ins_rhs(a_rhs), .ins_valid(a_valid),
    .ins_ready(a_ready), .outs(a_outs), .outs_valid(a_ovalid), .outs_ready(a_oready),
    .unit_lhs(a_ulhs), .unit_rhs(a_urhs), .unit_valid(a_uvalid), .unit_result(a_ures));

  always @(posedge clk) a_ures <= fmin(a_ulhs, a_urhs);

  // ---------------- instance B: LATENCY=3 ----------------
  logic              b_rst;
  logic [NR*DW-1:0]  b_lhs, b_rhs, b_outs;
  logic [NR-1:0]     b_valid, b_ready, b_ovalid, b_oready;
  logic [DW-1:0]     b_ulhs, b_urhs, b_ures;
  logic              b_uvalid;
  logic [DW-1:0]     b_pipe [3];

  minf_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .LATENCY(3), .FIFO_DEPTH(DEP)) dut_b (
    .clk(clk), .rst(b_rst), .ins_lhs(b_lhs), .ins_rhs(b_rhs), .ins_valid(b_valid),
    .ins_ready(b_ready), .outs(b_outs), .outs_valid(b_ovalid), .outs_ready(b_oready),
    .unit_lhs(b_ulhs), .unit_rhs(b_urhs), .unit_valid(b_uvalid), .unit_result(b_ures));

  always @(posedge clk) begin
    b_pipe[0] <= fmin(b_ulhs, b_urhs);
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_ures = b_pipe[2];

  // ---------------- scoreboards ----------------
  logic [31:0] a_exp [NR][$];
  logic [31:0] b_exp [NR][$];

  always @(negedge clk) begin
    if (a_rst) begin
      for (int i = 0; i < NR; i++) a_exp[i].delete();
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (a_ovalid[i] && a_oready[i]) begin
          check("a_sb_expected", 32'(a_exp[i].size() != 0), 32'd1);
          if (a_exp[i].size() != 0) check("a_sb_data", a_outs[i*DW +: DW], a_exp[i].pop_front());
        end
        if (a_valid[i] && a_ready[i]) a_exp[i].push_back(fmin(a_lhs[i*DW +: DW], a_rhs[i*DW +: DW]));
      end
    end
  end

  always @(negedge clk) begin
    if (b_rst) begin
      for (int i = 0; i < NR; i++) b_exp[i].delete();
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (b_ovalid[i] && b_oready[i]) begin
          check("b_sb_expected", 32'(b_exp[i].size() != 0), 32'd1);
          if (b_exp[i].size() != 0) check("b_sb_data", b_outs[i*DW +: DW], b_exp[i].pop_front());
        end
        if (b_valid[i] && b_ready[i]) b_exp[i].push_back(fmin(b_lhs[i*DW +: DW], b_rhs[i*DW +: DW]));
      end
    end
  end

  task automatic a_rand();
    for (int i = 0; i < NR; i++) begin
      a_lhs[i*DW +: DW] = rnd_op(i);
      a_rhs[i*DW +: DW] = rnd_op(i);
    end
  endtask

  task automatic b_rand();
    for (int i = 0; i < NR; i++) begin
      b_lhs[i*DW +: DW] = rnd_op(i);
      b_rhs[i*DW +: DW] = rnd_op(i);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [3:0] vld;
    logic [3:0] rdy;
  } vec_t;

  initial begin
    vec_t tbl [8];
    int   g1, gt, exp_g, g;

    // Pointer starts this table at 3 (left there by the single-request test on req 2).
    tbl[0] = '{4'b0000, 4'b0000};
    tbl[1] = '{4'b1111, 4'b1000};
    tbl[2] = '{4'b0110, 4'b0010};
    tbl[3] = '{4'b0011, 4'b0001};
    tbl[4] = '{4'b0001, 4'b0001};
    tbl[5] = '{4'b1010, 4'b0010};
    tbl[6] = '{4'b1001, 4'b1000};
    tbl[7] = '{4'b0100, 4'b0100};

    a_rst = 1'b1; b_rst = 1'b1;
    a_valid = '0; b_valid = '0;
    a_oready = '1; b_oready = '1;
    a_lhs = '0; a_rhs = '0; b_lhs = '0; b_rhs = '0;
    step(2);

    // Nothing may be accepted while reset is held.
    a_valid = '1;
    @(negedge clk);
    check("rst_ins_ready", 32'(a_ready), 32'd0);
    check("rst_unit_valid", 32'(a_uvalid), 32'd0);
    step(1);
    a_valid = '0;
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    check("post_rst_outs_valid", 32'(a_ovalid), 32'd0);
    check("post_rst_unit_valid", 32'(a_uvalid), 32'd0);
    step(1);

    // Single requester: req 2, min(1.0, 2.0).
    a_lhs[2*DW +: DW] = 32'h3F800000;
    a_rhs[2*DW +: DW] = 32'h40000000;
    a_valid = 4'b0100;
    @(negedge clk);
    check("single_ready", 32'(a_ready), 32'(4'b0100));
    check("single_unit_lhs", a_ulhs, 32'h3F800000);
    step(1);
    a_valid = '0;
    @(negedge clk);
    check("single_not_early", 32'(a_ovalid), 32'd0);
    step(1);
    @(negedge clk);
    check("single_outs_valid", 32'(a_ovalid), 32'(4'b0100));
    check("single_outs", a_outs[2*DW +: DW], 32'h3F800000);
    step(1);

    // Table-driven arbitration: one cycle per vector, then drain so credits refill.
    for (int t = 0; t < 8; t++) begin
      a_rand();
      a_valid = tbl[t].vld;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", t), 32'(a_ready), 32'(tbl[t].rdy));
      check($sformatf("tbl%0d_uvalid", t), 32'(a_uvalid), 32'(tbl[t].rdy != 4'b0000));
      for (int j = 0; j < NR; j++)
        if (tbl[t].rdy[j]) check($sformatf("tbl%0d_unit_lhs", t), a_ulhs, a_lhs[j*DW +: DW]);
      step(1);
      a_valid = '0;
      step(4);
    end

    // All requesters valid: strict rotation from pointer 3, one grant per cycle.
    exp_g = 3;
    for (int k = 0; k < 16; k++) begin
      a_rand();
      a_valid = '1;
      @(negedge clk);
      g = -1;
      for (int j = 0; j < NR; j++) if (a_ready[j]) g = j;
      check("rr_one_grant", 32'($countones(a_ready)), 32'd1);
      check("rr_order", 32'(g), 32'(exp_g));
      exp_g = (exp_g + 1) % NR;
      step(1);
    end
    a_valid = '0;
    step(6);

    // Backpressure on req 1: only FIFO_DEPTH grants, others keep flowing.
    a_oready = 4'b1101;
    g1 = 0; gt = 0;
    for (int k = 0; k < 16; k++) begin
      a_rand();
      a_valid = '1;
      @(negedge clk);
      g1 += int'(a_ready[1]);
      gt += $countones(a_ready);
      step(1);
    end
    check("bp_req1_grants", 32'(g1), 32'(DEP));
    check("bp_total_grants", 32'(gt), 32'd16);

    // Pop on a full FIFO with zero credit: no grant this cycle, grant next cycle.
    a_valid = 4'b0010;
    a_oready = 4'b1111;
    @(negedge clk);
    check("pop_cycle_no_grant", 32'(a_ready), 32'd0);
    check("pop_cycle_full_valid", 32'(a_ovalid[1]), 32'd1);
    step(1);
    a_oready = 4'b1101;
    @(negedge clk);
    check("grant_after_pop", 32'(a_ready), 32'(4'b0010));
    step(1);
    g1 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      g1 += int'(a_ready[1]);
      step(1);
    end
    check("no_extra_grant", 32'(g1), 32'd0);
    a_valid = '0;
    a_oready = '1;
    step(8);

    // LATENCY=3: interleaved reqs 0 and 3, tags must route each result home.
    b_valid = 4'b1001;
    for (int k = 0; k < 20; k++) begin
      b_rand();
      @(negedge clk);
      if (k == 0) check("b_first_grant", 32'(b_ready), 32'(4'b0001));
      step(1);
    end
    b_valid = '0;
    step(10);

    // Reset with req 0 FIFO holding results and three ops in flight.
    b_oready = 4'b1110;
    b_rand();
    b_valid = 4'b0001;
    step(2);
    b_valid = '0;
    step(6);
    b_valid = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      b_rand();
      @(negedge clk);
      check("b_inflight_grant", 32'($countones(b_ready)), 32'd1);
      step(1);
    end
    b_valid = '0;
    b_rst = 1'b1;
    @(negedge clk);
    check("b_fifo0_before_rst_clear", 32'(b_ovalid[0]), 32'd1);
    step(1);
    b_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("b_post_rst_outs_valid", 32'(b_ovalid), 32'd0);
      step(1);
    end
    // Full credits everywhere: exactly DEP grants per requester, starting at req 0.
    b_oready = '0;
    b_valid = '1;
    gt = 0;
    for (int k = 0; k < 10; k++) begin
      b_rand();
      @(negedge clk);
      if (k == 0) check("b_post_rst_ptr", 32'(b_ready), 32'(4'b0001));
      gt += $countones(b_ready);
      step(1);
    end
    check("b_post_rst_credits", 32'(gt), 32'(NR * DEP));
    b_valid = '0;
    b_oready = '1;
    step(12);

    for (int i = 0; i < NR; i++) begin
      check("a_sb_drained", 32'(a_exp[i].size()), 32'd0);
      check("b_sb_drained", 32'(b_exp[i].size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
